// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the MIPS decoder and hazard control.
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      ERR  = 2'd2
   } hz_state_t;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc,
   output logic [CW-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (inc && count != '1)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline stall/flush control with memory-wait watchdog.
module hazard_unit
   import pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CW          = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [4:0]    id_rs,
   input  logic [4:0]    id_rt,
   input  logic          id_uses_rs,
   input  logic          id_uses_rt,
   input  logic          id_jump,
   input  logic          ex_memread,
   input  logic [4:0]    ex_rt,
   input  logic          mem_branch_taken,
   input  logic          mem_req,
   input  logic          mem_ready,
   output logic          pc_write,
   output logic          ifid_write,
   output logic          idex_write,
   output logic          exmem_write,
   output logic          memwb_write,
   output logic          ctrl_enable,
   output logic          ifid_flush,
   output logic          idex_flush,
   output logic          exmem_flush,
   output logic          mem_timeout,
   output logic [CW-1:0] stall_count,
   output logic [CW-1:0] flush_count
);

   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WW-1:0] LIMIT = WW'(MEM_TIMEOUT);

   hz_state_t     state, state_nx;
   logic [WW-1:0] wcnt, wcnt_nx, wcnt_inc;
   logic          timeout_nx;
   logic          freeze, load_use;
   logic          stall_inc, flush_inc;

   assign freeze   = mem_req & ~mem_ready;
   assign wcnt_inc = wcnt + 1'b1;
   assign load_use = ex_memread && ex_rt != 5'd0 &&
                     ((id_uses_rs && ex_rt == id_rs) ||
                      (id_uses_rt && ex_rt == id_rt));

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_write  = 1'b1;
      exmem_write = 1'b1;
      memwb_write = 1'b1;
      ctrl_enable = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      state_nx    = state;
      wcnt_nx     = wcnt;
      timeout_nx  = mem_timeout;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      if (reset) begin
         {pc_write, ifid_write, idex_write} = 3'b000;
         {exmem_write, memwb_write}         = 2'b00;
         ctrl_enable                        = 1'b0;
         {ifid_flush, idex_flush}           = 2'b11;
         exmem_flush                        = 1'b1;
      end else if (state == ERR) begin
         {pc_write, ifid_write, idex_write} = 3'b000;
         {exmem_write, memwb_write}         = 2'b00;
         ctrl_enable                        = 1'b0;
      end else if (freeze) begin
         {pc_write, ifid_write, idex_write} = 3'b000;
         {exmem_write, memwb_write}         = 2'b00;
         stall_inc                          = 1'b1;
         // wcnt is 0 in RUN, so one increment covers both entry and waiting
         if (wcnt_inc == LIMIT) begin
            state_nx   = ERR;
            timeout_nx = 1'b1;
         end else begin
            state_nx = WAIT;
            wcnt_nx  = wcnt_inc;
         end
      end else begin
         state_nx = RUN;
         wcnt_nx  = '0;
         if (mem_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            flush_inc   = 1'b1;
         end else if (id_jump) begin
            ifid_flush = 1'b1;
            flush_inc  = 1'b1;
         end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ctrl_enable = 1'b0;
            stall_inc   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RUN;
         wcnt        <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state       <= state_nx;
         wcnt        <= wcnt_nx;
         mem_timeout <= timeout_nx;
      end
   end

   sat_counter #(.CW(CW)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_inc),
      .count (stall_count)
   );

   sat_counter #(.CW(CW)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush_inc),
      .count (flush_count)
   );

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized scoreboard bench for hazard_unit against a behavioural model.
module tb_hazard_unit;

   localparam int MT = 4;
   localparam int CW = 2;
   localparam int OW = 10 + 2 * CW;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic       jmp;
      logic       exmr;
      logic [4:0] exrt;
      logic       br;
      logic       req;
      logic       rdy;
   } stim_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [4:0]    id_rs = '0, id_rt = '0, ex_rt = '0;
   logic          id_uses_rs = 0, id_uses_rt = 0, id_jump = 0;
   logic          ex_memread = 0, mem_branch_taken = 0;
   logic          mem_req = 0, mem_ready = 0;
   logic          pc_write, ifid_write, idex_write, exmem_write;
   logic          memwb_write, ctrl_enable;
   logic          ifid_flush, idex_flush, exmem_flush, mem_timeout;
   logic [CW-1:0] stall_count, flush_count;

   int checks = 0;
   int errors = 0;
   logic [OW-1:0] exp_q[$];

   // behavioural model: 0 = running, 1 = waiting, 2 = error
   int m_mode = 0;
   int m_waited = 0;
   int m_stalls = 0;
   int m_flushes = 0;
   bit m_err = 0;

   always #5 clk = ~clk;

   hazard_unit #(.MEM_TIMEOUT(MT), .CW(CW)) dut (
      .clk              (clk),
      .reset            (reset),
      .id_rs            (id_rs),
      .id_rt            (id_rt),
      .id_uses_rs       (id_uses_rs),
      .id_uses_rt       (id_uses_rt),
      .id_jump          (id_jump),
      .ex_memread       (ex_memread),
      .ex_rt            (ex_rt),
      .mem_branch_taken (mem_branch_taken),
      .mem_req          (mem_req),
      .mem_ready        (mem_ready),
      .pc_write         (pc_write),
      .ifid_write       (ifid_write),
      .idex_write       (idex_write),
      .exmem_write      (exmem_write),
      .memwb_write      (memwb_write),
      .ctrl_enable      (ctrl_enable),
      .ifid_flush       (ifid_flush),
      .idex_flush       (idex_flush),
      .exmem_flush      (exmem_flush),
      .mem_timeout      (mem_timeout),
      .stall_count      (stall_count),
      .flush_count      (flush_count)
   );

   function automatic stim_t idle();
      stim_t s = '0;
      return s;
   endfunction

   // writes {pc,ifid,idex,exmem,memwb}, ctrl, flushes {ifid,idex,exmem}
   task automatic apply(input stim_t s);
      bit [4:0] wr;
      bit       ce;
      bit [2:0] fl;
      bit       hz;
      @(negedge clk);
      #1;
      reset            = s.rst;
      id_rs            = s.rs;
      id_rt            = s.rt;
      id_uses_rs       = s.urs;
      id_uses_rt       = s.urt;
      id_jump          = s.jmp;
      ex_memread       = s.exmr;
      ex_rt            = s.exrt;
      mem_branch_taken = s.br;
      mem_req          = s.req;
      mem_ready        = s.rdy;
      hz = s.exmr && s.exrt != 0 &&
           ((s.urs && s.exrt == s.rs) || (s.urt && s.exrt == s.rt));
      wr = 5'b11111; ce = 1; fl = 3'b000;
      if (s.rst) begin
         wr = 0; ce = 0; fl = 3'b111;
      end else if (m_mode == 2) begin
         wr = 0; ce = 0;
      end else if (s.req && !s.rdy) begin
         wr = 0;
      end else if (s.br) begin
         fl = 3'b111;
      end else if (s.jmp) begin
         fl = 3'b100;
      end else if (hz) begin
         wr = 5'b00111; ce = 0;
      end
      exp_q.push_back({wr, ce, fl, m_err,
                       CW'(m_stalls), CW'(m_flushes)});
      if (s.rst) begin
         m_mode = 0; m_waited = 0;
         m_stalls = 0; m_flushes = 0; m_err = 0;
      end else if (m_mode != 2) begin
         if (s.req && !s.rdy) begin
            m_waited++;
            m_stalls = (m_stalls < CMAX) ? m_stalls + 1 : CMAX;
            if (m_waited >= MT) begin
               m_mode = 2; m_err = 1;
            end else begin
               m_mode = 1;
            end
         end else begin
            m_mode = 0; m_waited = 0;
            if (s.br || s.jmp)
               m_flushes = (m_flushes < CMAX) ? m_flushes + 1 : CMAX;
            else if (hz)
               m_stalls = (m_stalls < CMAX) ? m_stalls + 1 : CMAX;
         end
      end
   endtask

   initial begin : monitor
      logic [OW-1:0] e, a;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {pc_write, ifid_write, idex_write, exmem_write,
                 memwb_write, ctrl_enable, ifid_flush, idex_flush,
                 exmem_flush, mem_timeout, stall_count, flush_count};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL outputs t=%0t actual=%b required=%b",
                        $time, a, e);
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : stimulus
      stim_t s;
      // reset held two cycles
      s = idle(); s.rst = 1;
      repeat (2) apply(s);
      apply(idle());
      // load-use on rs
      s = idle(); s.exmr = 1; s.exrt = 8; s.rs = 8; s.urs = 1;
      apply(s);
      apply(idle());
      // same match against r0: no stall
      s.exrt = 0; s.rs = 0;
      apply(s);
      // branch over jump and load-use
      s = idle(); s.br = 1; s.jmp = 1; s.exmr = 1;
      s.exrt = 5; s.rt = 5; s.urt = 1;
      apply(s);
      apply(idle());
      // memory wait of three cycles
      s = idle(); s.rst = 1;
      apply(s);
      s = idle(); s.req = 1;
      repeat (3) apply(s);
      s.rdy = 1;
      apply(s);
      s = idle(); s.jmp = 1;
      apply(s);
      apply(idle());
      // watchdog timeout, then reset recovery
      s = idle(); s.rst = 1;
      apply(s);
      s = idle(); s.req = 1; s.jmp = 1;
      repeat (6) apply(s);
      s = idle(); s.rst = 1;
      apply(s);
      apply(idle());
      // flush counter saturation
      s = idle(); s.jmp = 1;
      repeat (5) apply(s);
      apply(idle());
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         s      = idle();
         s.rst  = ($urandom_range(0, 99) < 4);
         s.rs   = 5'($urandom_range(0, 3));
         s.rt   = 5'($urandom_range(0, 3));
         s.urs  = 1'($urandom);
         s.urt  = 1'($urandom);
         s.jmp  = ($urandom_range(0, 99) < 15);
         s.exmr = ($urandom_range(0, 99) < 40);
         s.exrt = 5'($urandom_range(0, 3));
         s.br   = ($urandom_range(0, 99) < 12);
         s.req  = ($urandom_range(0, 99) < 35);
         s.rdy  = 1'($urandom);
         apply(s);
      end
      apply(idle());
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: pending=%0d required=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
